tl45_regfile_sb: RTL and testbench

//   Parametrised multi-read-port register file with integrated busy scoreboard for the
//   tl45 core. Successor to the fixed 2-read/15-entry file: configurable width, depth and

---
 rtl/tl45_regfile_sb_if.sv | 34 +++
 rtl/tl45_regfile_sb.sv | 83 ++++++++
 tb/tb_tl45_regfile_sb.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/tl45_regfile_sb_if.sv
// Bus between decode/writeback and the tl45 register file with busy scoreboard.
// Decode drives reads and busy sets, writeback drives writes and clears.
interface tl45_regfile_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     sb_set_en;
    logic [AW-1:0]            sb_set_addr;
    logic                     sb_clr_en;
    logic [AW-1:0]            sb_clr_addr;
    logic                     sb_flush;
    logic [NUM_REGS-1:0]      busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
               sb_set_en, sb_set_addr, sb_clr_en, sb_clr_addr, sb_flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
               sb_set_en, sb_set_addr, sb_clr_en, sb_clr_addr, sb_flush,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/tl45_regfile_sb.sv
// tl45 register file: NUM_RD registered read ports with write-through bypass,
// r0 hardwired to zero, and a per-register busy scoreboard with flush.
module tl45_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    tl45_regfile_sb_if.slave      bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]        regs [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
    logic [AW-1:0]            ra [NUM_RD];

    // r0 and addresses past the last register behave as a constant-zero, never-busy slot.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < NUM_REGS);
    endfunction

    for (genvar i = 0; i < NUM_RD; i++) begin : g_ra
        assign ra[i] = bus.rd_addr[i*AW +: AW];
    end

    // NOTE: every variable driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (bus.sb_set_en && bus.sb_set_addr == AW'(r))
                busy_d[r] = 1'b1;   // a new producer wins over flush and retire
            else if (bus.sb_flush)
                busy_d[r] = 1'b0;
            else if (bus.sb_clr_en && bus.sb_clr_addr == AW'(r))
                busy_d[r] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // Reads see the state as it will be after this edge: written data and next busy.
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (in_range(ra[i])) begin
                if (bus.wr_en && bus.wr_addr == ra[i])
                    rd_data_d[i*DATA_W +: DATA_W] = bus.wr_data;
                else
                    rd_data_d[i*DATA_W +: DATA_W] = regs[ra[i]];
                rd_busy_d[i] = busy_d[ra[i]];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the architectural registers must read zero after reset, so the
            // storage array is cleared here rather than left uninitialised.
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            if (bus.wr_en && in_range(bus.wr_addr))
                regs[bus.wr_addr] <= bus.wr_data;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_tl45_regfile_sb.sv
// Self-checking bench for tl45_regfile_sb: directed vector table, hand-written
// corner sequence, then random traffic against a state-after-edge reference model.
module tb_tl45_regfile_sb;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int NUM_RD   = 2;
    localparam int AW       = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    tl45_regfile_sb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) bus ();

    tl45_regfile_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [AW-1:0] ra0, ra1;
        logic          we;
        logic [AW-1:0] wa;
        logic [31:0]   wd;
        logic          se;
        logic [AW-1:0] sa;
        logic          ce;
        logic [AW-1:0] ca;
        logic          fl;
        logic [31:0]   e_d0, e_d1;
        logic [1:0]    e_busy;
        logic [15:0]   e_vec;
    } vec_t;

    vec_t tbl [16];

    // Reference model: architectural state after each edge.
    logic [31:0] m_mem  [NUM_REGS];
    logic        m_busy [NUM_REGS];
    logic [31:0] m_data [NUM_RD];
    logic        m_rbsy [NUM_RD];

    function automatic logic m_valid(input logic [AW-1:0] a);
        return a != 0 && int'(a) < NUM_REGS;
    endfunction

    task automatic model_update();
        logic [AW-1:0] a;
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                m_mem[r]  = '0;
                m_busy[r] = 1'b0;
            end
            for (int i = 0; i < NUM_RD; i++) begin
                m_data[i] = '0;
                m_rbsy[i] = 1'b0;
            end
            return;
        end
        if (bus.wr_en && m_valid(bus.wr_addr)) m_mem[bus.wr_addr] = bus.wr_data;
        // Apply lowest-priority effects first so later ones override.
        if (bus.sb_flush)
            for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 1'b0;
        if (bus.sb_clr_en && m_valid(bus.sb_clr_addr)) m_busy[bus.sb_clr_addr] = 1'b0;
        if (bus.sb_set_en && m_valid(bus.sb_set_addr)) m_busy[bus.sb_set_addr] = 1'b1;
        for (int i = 0; i < NUM_RD; i++) begin
            a = bus.rd_addr[i*AW +: AW];
            m_data[i] = m_valid(a) ? m_mem[a] : 32'h0;
            m_rbsy[i] = m_valid(a) ? m_busy[a] : 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset           = v.rst;
        bus.rd_addr     = {v.ra1, v.ra0};
        bus.wr_en       = v.we;
        bus.wr_addr     = v.wa;
        bus.wr_data     = v.wd;
        bus.sb_set_en   = v.se;
        bus.sb_set_addr = v.sa;
        bus.sb_clr_en   = v.ce;
        bus.sb_clr_addr = v.ca;
        bus.sb_flush    = v.fl;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic vec_t idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        vec_t v;
        v = '{1'b0, ra0, ra1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0,
              32'h0, 32'h0, 2'b00, 16'h0};
        return v;
    endfunction

    initial begin
        vec_t v;

        //          rst ra0 ra1 we wa  wd            se sa ce ca fl  e_d0          e_d1          busy   vec
        tbl[0]  = '{1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 16'h0000};
        tbl[1]  = '{0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 16'h0000};
        tbl[2]  = '{0, 5, 0, 1, 0, 32'h00001234, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0,        2'b00, 16'h0000};
        tbl[3]  = '{0, 0, 7, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 32'h0,        32'hA5A5A5A5, 2'b00, 16'h0000};
        tbl[4]  = '{0, 7, 5, 0, 0, 32'h0,        1, 3, 1, 3, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b00, 16'h0008};
        tbl[5]  = '{0, 3, 4, 0, 0, 32'h0,        1, 4, 0, 0, 0, 32'h0,        32'h0,        2'b11, 16'h0018};
        tbl[6]  = '{0, 3, 4, 0, 0, 32'h0,        0, 0, 1, 3, 0, 32'h0,        32'h0,        2'b10, 16'h0010};
        tbl[7]  = '{0, 2, 4, 0, 0, 32'h0,        1, 2, 1, 4, 0, 32'h0,        32'h0,        2'b01, 16'h0004};
        tbl[8]  = '{0, 1, 2, 0, 0, 32'h0,        1, 1, 0, 0, 0, 32'h0,        32'h0,        2'b11, 16'h0006};
        tbl[9]  = '{0, 6, 1, 0, 0, 32'h0,        1, 6, 0, 0, 0, 32'h0,        32'h0,        2'b11, 16'h0046};
        tbl[10] = '{0, 9, 6, 0, 0, 32'h0,        1, 9, 0, 0, 0, 32'h0,        32'h0,        2'b11, 16'h0246};
        tbl[11] = '{0, 8, 9, 0, 0, 32'h0,        1, 8, 0, 0, 1, 32'h0,        32'h0,        2'b01, 16'h0100};
        tbl[12] = '{1, 5, 8, 1, 5, 32'h00000055, 1, 5, 0, 0, 0, 32'h0,        32'h0,        2'b00, 16'h0000};
        tbl[13] = '{0, 5, 7, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 16'h0000};
        tbl[14] = '{0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 16'h0000};
        tbl[15] = '{0, 3, 3, 1, 3, 32'hCAFEF00D, 0, 0, 1, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 16'h0000};

        for (int k = 0; k < 16; k++) begin
            drive(tbl[k]);
            cycle();
            check($sformatf("row%0d_d0", k),   bus.rd_data[31:0],  tbl[k].e_d0);
            check($sformatf("row%0d_d1", k),   bus.rd_data[63:32], tbl[k].e_d1);
            check($sformatf("row%0d_busy", k), 32'(bus.rd_busy),   32'(tbl[k].e_busy));
            check($sformatf("row%0d_vec", k),  32'(bus.busy_vec),  32'(tbl[k].e_vec));
        end

        // Top register: write + set, hold across idle cycles, then retire.
        v = idle(0, 0);
        v.we = 1; v.wa = 15; v.wd = 32'h0F0F1234; v.se = 1; v.sa = 15;
        drive(v);
        cycle();
        drive(idle(0, 0));
        for (int k = 0; k < 3; k++) cycle();
        check("hold_vec15", 32'(bus.busy_vec), 32'h00008000);
        drive(idle(0, 15));
        cycle();
        check("hold_d15",    bus.rd_data[63:32], 32'h0F0F1234);
        check("hold_busy15", 32'(bus.rd_busy),   32'h2);
        v = idle(15, 0);
        v.ce = 1; v.ca = 15;
        drive(v);
        cycle();
        check("clr_busy15", 32'(bus.rd_busy),  32'h0);
        check("clr_vec15",  32'(bus.busy_vec), 32'h0);

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            v = idle(AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
            v.rst = ($urandom_range(0, 63) == 0);
            v.we  = $urandom_range(0, 1);
            v.wa  = AW'($urandom_range(0, 15));
            v.wd  = $urandom;
            v.se  = $urandom_range(0, 1);
            v.sa  = AW'($urandom_range(0, 15));
            v.ce  = $urandom_range(0, 1);
            v.ca  = ($urandom_range(0, 3) == 0) ? v.sa : AW'($urandom_range(0, 15));
            v.fl  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) v.ra1 = v.wa;
            drive(v);
            cycle();
            for (int i = 0; i < NUM_RD; i++) begin
                check($sformatf("rnd%0d_d%0d", n, i), bus.rd_data[i*DATA_W +: DATA_W], m_data[i]);
                check($sformatf("rnd%0d_b%0d", n, i), 32'(bus.rd_busy[i]), 32'(m_rbsy[i]));
            end
            for (int r = 0; r < NUM_REGS; r++)
                check($sformatf("rnd%0d_vec%0d", n, r), 32'(bus.busy_vec[r]), 32'(m_busy[r]));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
